// File: rtl/imem_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : imem_pkg
// Purpose : Shared constants and loader state encoding for the instruction
//           memory loader and its byte packer.
// Contents: IMEM_ADDR_W  byte-address width of the instruction memory
//           IMEM_DEPTH   number of 32-bit words
//           NOP_WORD     fill pattern for unused lanes of a short final word
//           ld_state_e   loader FSM states
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package imem_pkg;

   localparam int          IMEM_ADDR_W = 11;
   localparam int          IMEM_DEPTH  = 512;
   localparam logic [31:0] NOP_WORD    = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_RECV  = 2'd1,
      LD_WRITE = 2'd2,
      LD_DONE  = 2'd3
   } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : byte_packer
// Purpose : Assembles four little-endian stream bytes into one 32-bit word.
//           Byte k of a word lands in bits [8k+7:8k]. When the final byte of
//           the image arrives before lane 3, the lanes above it are filled
//           from PAD_WORD so the short word is still a valid instruction.
// Ports   : i_clk, i_rst_n  clock / asynchronous active-low reset
//           i_clear         restart at lane 0 (new load)
//           i_load          accept i_byte this cycle
//           i_byte          stream byte
//           i_last          i_byte is the last byte of the image
//           o_word          assembled word (stable until the next i_load)
//           o_complete      this accepted byte finishes a word
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module byte_packer
   import imem_pkg::*;
#(
   parameter logic [31:0] PAD_WORD = NOP_WORD
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic [7:0]  i_byte,
   input  logic        i_last,
   output logic [31:0] o_word,
   output logic        o_complete
);

   logic [1:0]  r_idx;
   logic [31:0] r_word;
   logic [31:0] w_next_word;

   // Per lane: take the incoming byte in the current lane, pad the lanes
   // above it when this is the final byte, otherwise keep what is held.
   // Lanes above the index that are not padded hold stale data, but they are
   // always overwritten before the word completes.
   generate
      for (genvar k = 0; k < 4; k++) begin : g_lane
         localparam logic [1:0] c_lane = 2'(k);
         assign w_next_word[8*k +: 8] =
            (r_idx == c_lane)              ? i_byte                :
            (i_last && (c_lane > r_idx))   ? PAD_WORD[8*k +: 8]    :
                                             r_word[8*k +: 8];
      end
   endgenerate

   assign o_complete = i_load && ((r_idx == 2'd3) || i_last);
   assign o_word     = r_word;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx  <= 2'd0;
         r_word <= 32'd0;
      end else if (i_clear) begin
         r_idx  <= 2'd0;
      end else if (i_load) begin
         r_word <= w_next_word;
         r_idx  <= o_complete ? 2'd0 : r_idx + 2'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : imem_loader
// Purpose : Write-side loader for the instruction memory. Takes a byte stream
//           (valid/ready), packs 4 bytes per word and writes consecutive words
//           from byte address 0 upward, holding the core in stall meanwhile.
// Ports   : i_clk, i_rst_n   clock / asynchronous active-low reset
//           i_start          begin a new load (honoured in IDLE or DONE only)
//           i_byte/i_valid   stream byte and its qualifier
//           i_last           marks the final byte of the image
//           o_ready          loader accepts a byte this cycle
//           o_we/o_waddr/o_wdata  memory write port, one pulse per word
//           o_busy           load in progress
//           o_done           image written; held until next i_start/reset
//           o_overflow       sticky: byte offered after memory filled
//           o_word_cnt       words written in the current load
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module imem_loader
   import imem_pkg::*;
#(
   parameter int          ADDR_W   = IMEM_ADDR_W,
   parameter int          DEPTH    = IMEM_DEPTH,
   parameter logic [31:0] PAD_WORD = NOP_WORD
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [7:0]        i_byte,
   input  logic              i_valid,
   input  logic              i_last,
   output logic              o_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [31:0]       o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overflow,
   output logic [ADDR_W-2:0] o_word_cnt
);

   // Counter value while the final word of the memory is being written.
   localparam logic [ADDR_W-2:0] c_last_word = (ADDR_W-1)'(DEPTH - 1);

   ld_state_e         r_state;
   ld_state_e         w_next_state;
   logic [ADDR_W-2:0] r_word_cnt;
   logic              r_last_seen;
   logic              r_overflow;
   logic              w_accept;
   logic              w_complete;
   logic              w_clear;
   logic [31:0]       w_word;

   assign w_accept = i_valid && (r_state == LD_RECV);
   assign w_clear  = i_start && ((r_state == LD_IDLE) || (r_state == LD_DONE));

   byte_packer #(
      .PAD_WORD   (PAD_WORD)
   ) u_packer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clear    (w_clear),
      .i_load     (w_accept),
      .i_byte     (i_byte),
      .i_last     (i_last),
      .o_word     (w_word),
      .o_complete (w_complete)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= LD_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         LD_IDLE:  if (i_start)    w_next_state = LD_RECV;
         LD_RECV:  if (w_complete) w_next_state = LD_WRITE;
         LD_WRITE: w_next_state = (r_last_seen || (r_word_cnt == c_last_word))
                                  ? LD_DONE : LD_RECV;
         LD_DONE:  if (i_start)    w_next_state = LD_RECV;
         default:  w_next_state = LD_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      o_ready = 1'b0;
      o_we    = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (r_state)
         LD_RECV:  begin o_ready = 1'b1; o_busy = 1'b1; end
         LD_WRITE: begin o_we    = 1'b1; o_busy = 1'b1; end
         LD_DONE:  o_done = 1'b1;
         default:  ;
      endcase
   end

   // Word counter, end-of-image marker and overflow flag. The counter steps
   // on the edge that ends the write cycle, so o_waddr reflects the word
   // being written during LD_WRITE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word_cnt  <= '0;
         r_last_seen <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_clear) begin
         r_word_cnt  <= '0;
         r_last_seen <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_accept && w_complete) r_last_seen <= i_last;
         if (r_state == LD_WRITE)    r_word_cnt  <= r_word_cnt + 1'b1;
         if ((r_state == LD_DONE) && i_valid) r_overflow <= 1'b1;
      end
   end

   // The counter never exceeds DEPTH-1 during a write, so dropping its top
   // bit keeps the address in range without wrapping.
   assign o_waddr    = {r_word_cnt[ADDR_W-3:0], 2'b00};
   assign o_wdata    = w_word;
   assign o_word_cnt = r_word_cnt;
   assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_imem_loader
// Purpose : Self-checking bench for imem_loader: cycle table for the basic
//           loads, then hand-written partial, full/overflow and abort cases.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_imem_loader;
   import imem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  bt;
   logic        valid;
   logic        last;
   logic        o_ready, o_we, o_busy, o_done, o_overflow;
   logic [10:0] o_waddr;
   logic [31:0] o_wdata;
   logic [9:0]  o_word_cnt;

   always #5 clk = ~clk;

   imem_loader dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_byte     (bt),
      .i_valid    (valid),
      .i_last     (last),
      .o_ready    (o_ready),
      .o_we       (o_we),
      .o_waddr    (o_waddr),
      .o_wdata    (o_wdata),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_overflow (o_overflow),
      .o_word_cnt (o_word_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Memory model fed from the write port
   int          wr_cnt = 0;
   logic [10:0] last_addr = '0;
   logic [31:0] last_data = '0;
   logic [31:0] mem     [0:511];
   logic [31:0] exp_mem [0:511];

   always @(negedge clk) begin
      if (o_we === 1'b1) begin
         wr_cnt    = wr_cnt + 1;
         last_addr = o_waddr;
         last_data = o_wdata;
         mem[o_waddr[10:2]] = o_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offer one byte until accepted (bounded); returns at posedge+1 after acceptance.
   task automatic send_byte(input logic [7:0] b, input logic l);
      logic ok;
      ok    = 1'b0;
      bt    = b;
      last  = l;
      valid = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = o_ready;
         @(posedge clk); #1;
      end
      valid = 1'b0;
      last  = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_byte timeout: byte %h not accepted, ready %b expected 1", b, o_ready);
      end
   endtask

   task automatic wait_done(input string name, input int n);
      logic ok;
      ok = 1'b0;
      for (int t = 0; t < n && !ok; t++) begin
         @(negedge clk);
         ok = o_done;
      end
      check(name, 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        st;
      logic        v;
      logic        l;
      logic [7:0]  b;
      logic        e_ready;
      logic        e_busy;
      logic        e_done;
      logic        e_we;
      logic [10:0] e_addr;
      logic [31:0] e_data;
      logic [9:0]  e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic v, input logic l, input logic [7:0] b,
                               input logic r, input logic bu, input logic d, input logic we,
                               input logic [10:0] a, input logic [31:0] dat, input logic [9:0] c);
      vec_t x;
      x.st = st; x.v = v; x.l = l; x.b = b;
      x.e_ready = r; x.e_busy = bu; x.e_done = d; x.e_we = we;
      x.e_addr = a; x.e_data = dat; x.e_cnt = c;
      return x;
   endfunction

   vec_t tbl [24];

   initial begin
      int ws;
      int mism;
      logic [7:0] v8;

      rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0; bt = 8'h00;

      //        st v  l  byte   rdy bsy dn we addr    data           cnt
      tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[1]  = mk(0, 1, 0, 8'h13, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[2]  = mk(0, 1, 0, 8'h05, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[3]  = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[4]  = mk(0, 1, 1, 8'h00, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[5]  = mk(0, 0, 0, 8'h00, 0, 1, 0, 1, 11'h0, 32'h0000_0513, 10'd0);
      tbl[6]  = mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 11'h0, 32'h0,         10'd1);
      tbl[7]  = mk(0, 1, 0, 8'h01, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[8]  = mk(0, 0, 0, 8'h77, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[9]  = mk(0, 1, 0, 8'h02, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[10] = mk(0, 0, 0, 8'h77, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[11] = mk(0, 1, 0, 8'h03, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[12] = mk(0, 0, 0, 8'h77, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[13] = mk(0, 1, 0, 8'h04, 1, 1, 0, 0, 11'h0, 32'h0,         10'd0);
      tbl[14] = mk(0, 0, 0, 8'h77, 0, 1, 0, 1, 11'h0, 32'h0403_0201, 10'd0);
      tbl[15] = mk(0, 1, 0, 8'h05, 1, 1, 0, 0, 11'h0, 32'h0,         10'd1);
      tbl[16] = mk(0, 0, 0, 8'h77, 1, 1, 0, 0, 11'h0, 32'h0,         10'd1);
      tbl[17] = mk(0, 1, 0, 8'h06, 1, 1, 0, 0, 11'h0, 32'h0,         10'd1);
      tbl[18] = mk(0, 0, 0, 8'h77, 1, 1, 0, 0, 11'h0, 32'h0,         10'd1);
      tbl[19] = mk(0, 1, 0, 8'h07, 1, 1, 0, 0, 11'h0, 32'h0,         10'd1);
      tbl[20] = mk(0, 0, 0, 8'h77, 1, 1, 0, 0, 11'h0, 32'h0,         10'd1);
      tbl[21] = mk(0, 1, 1, 8'h08, 1, 1, 0, 0, 11'h0, 32'h0,         10'd1);
      tbl[22] = mk(0, 0, 0, 8'h77, 0, 1, 0, 1, 11'h4, 32'h0807_0605, 10'd1);
      tbl[23] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 11'h0, 32'h0,         10'd2);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset ready",    32'(o_ready),    32'd0);
      check("reset we",       32'(o_we),       32'd0);
      check("reset busy",     32'(o_busy),     32'd0);
      check("reset done",     32'(o_done),     32'd0);
      check("reset overflow", 32'(o_overflow), 32'd0);
      check("reset word_cnt", 32'(o_word_cnt), 32'd0);
      check("reset waddr",    32'(o_waddr),    32'd0);
      check("reset wdata",    o_wdata,         32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Stream offered while idle is ignored
      valid = 1'b1; bt = 8'h5A;
      @(negedge clk);
      check("idle ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
      valid = 1'b0;
      check("idle busy", 32'(o_busy), 32'd0);
      check("idle no write", 32'(wr_cnt), 32'd0);

      // Cycle table: full word with last, then two words with gapped valid
      foreach (tbl[i]) begin
         start = tbl[i].st; valid = tbl[i].v; last = tbl[i].l; bt = tbl[i].b;
         @(negedge clk);
         check($sformatf("tbl[%0d] ready", i), 32'(o_ready),    32'(tbl[i].e_ready));
         check($sformatf("tbl[%0d] busy",  i), 32'(o_busy),     32'(tbl[i].e_busy));
         check($sformatf("tbl[%0d] done",  i), 32'(o_done),     32'(tbl[i].e_done));
         check($sformatf("tbl[%0d] we",    i), 32'(o_we),       32'(tbl[i].e_we));
         check($sformatf("tbl[%0d] cnt",   i), 32'(o_word_cnt), 32'(tbl[i].e_cnt));
         if (tbl[i].e_we) begin
            check($sformatf("tbl[%0d] waddr", i), 32'(o_waddr), 32'(tbl[i].e_addr));
            check($sformatf("tbl[%0d] wdata", i), o_wdata,      tbl[i].e_data);
         end
         @(posedge clk); #1;
      end
      start = 1'b0; valid = 1'b0; last = 1'b0;
      check("table write count", 32'(wr_cnt), 32'd3);

      // Partial final word padded from NOP lanes
      ws = wr_cnt;
      pulse_start();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b1);
      wait_done("partial done", 10);
      check("partial writes", 32'(wr_cnt - ws), 32'd1);
      check("partial waddr",  32'(last_addr),    32'd0);
      check("partial wdata",  last_data,         32'h0000_BBAA);
      check("partial cnt",    32'(o_word_cnt),   32'd1);

      // Fill the whole memory without i_last
      ws = wr_cnt;
      pulse_start();
      for (int w = 0; w < 512; w++) begin
         for (int k = 0; k < 4; k++) begin
            v8 = 8'((w * 7 + k * 61 + 3) & 255);
            exp_mem[w][8*k +: 8] = v8;
            send_byte(v8, 1'b0);
         end
      end
      wait_done("full done", 20);
      check("full writes",    32'(wr_cnt - ws), 32'd512);
      check("full last addr", 32'(last_addr),    32'h7FC);
      check("full cnt",       32'(o_word_cnt),   32'd512);
      check("full overflow",  32'(o_overflow),   32'd0);
      mism = 0;
      for (int w = 0; w < 512; w++)
         if (mem[w] !== exp_mem[w]) mism++;
      check("image compare mismatches", 32'(mism), 32'd0);

      // Extra byte after full: overflow, no write, dropped
      ws = wr_cnt;
      valid = 1'b1; bt = 8'hEE;
      @(negedge clk);
      check("overflow ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("overflow flag",   32'(o_overflow),   32'd1);
      check("overflow done",   32'(o_done),       32'd1);
      check("overflow no we",  32'(wr_cnt - ws),  32'd0);

      // New start clears status
      pulse_start();
      check("restart overflow", 32'(o_overflow), 32'd0);
      check("restart cnt",      32'(o_word_cnt), 32'd0);
      check("restart ready",    32'(o_ready),    32'd1);
      check("restart done",     32'(o_done),     32'd0);

      // Abort with reset after two bytes
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      ws = wr_cnt;
      rst_n = 1'b0;
      #2;
      check("abort ready", 32'(o_ready),    32'd0);
      check("abort busy",  32'(o_busy),     32'd0);
      check("abort we",    32'(o_we),       32'd0);
      check("abort cnt",   32'(o_word_cnt), 32'd0);
      check("abort wdata", o_wdata,         32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort no write", 32'(wr_cnt - ws), 32'd0);
      pulse_start();
      check("post-abort ready", 32'(o_ready), 32'd1);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      @(posedge clk); #1;
      check("post-abort writes", 32'(wr_cnt - ws), 32'd1);
      check("post-abort waddr",  32'(last_addr),    32'd0);
      check("post-abort wdata",  last_data,         32'h4433_2211);
      check("post-abort busy",   32'(o_busy),       32'd1);
      check("post-abort cnt",    32'(o_word_cnt),   32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
